// File: rtl/perceptron_pipe_ctrl.sv
// Valid/ready control for the perceptron datapath: bubble-collapsing valid pipeline,
// per-stage enables, weight-load ingress hold, flush and occupancy. Optional macro: PERCEPTRON_PIPE_STALL_CNT_EN.
module perceptron_pipe_ctrl #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned NW    = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NW-1:0]    wb_en_i,
  input  logic             flush_i,
  input  logic             val_i,
  output logic             rdy_o,
  output logic             val_o,
  input  logic             rdy_i,
  output logic [DEPTH-1:0] stage_en_o,
  output logic [CNT_W-1:0] occ_o,
  output logic             busy_o
`ifdef PERCEPTRON_PIPE_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt_o
`endif
);

  logic [DEPTH-1:0] r_v;
  logic [CNT_W-1:0] r_occ;
  logic [DEPTH-1:0] w_stage_en;
  logic             w_hold;
  logic             w_accept;
  logic             w_egress;

  // A stage may load when it or any stage downstream of it holds a bubble, or the sink is ready.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage_en
    assign w_stage_en[k] = rdy_i | ~(&r_v[DEPTH-1:k]);
  end

  assign w_hold     = |wb_en_i;
  assign rdy_o      = w_stage_en[0] & ~w_hold & ~flush_i & ~reset;
  assign w_accept   = val_i & rdy_o;
  assign w_egress   = r_v[DEPTH-1] & rdy_i;
  assign val_o      = r_v[DEPTH-1];
  assign stage_en_o = w_stage_en;
  assign occ_o      = r_occ;
  assign busy_o     = (r_occ != '0) | w_hold;

  // Valid bits and occupancy; flush wins over accept, advance and egress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v   <= '0;
      r_occ <= '0;
    end else if (flush_i) begin
      r_v   <= '0;
      r_occ <= '0;
    end else begin
      if (w_stage_en[0]) r_v[0] <= w_accept;
      for (int k = 1; k < DEPTH; k++) begin
        if (w_stage_en[k]) r_v[k] <= r_v[k-1];
      end
      r_occ <= r_occ + CNT_W'(w_accept) - CNT_W'(w_egress);
    end
  end

`ifdef PERCEPTRON_PIPE_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles the sink back-pressures a valid output; flush does not clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (r_v[DEPTH-1] && !rdy_i && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
